// File: rtl/program_counter_unit_if.sv
// rtl/program_counter_unit_if.sv - fetch-stage PC control/status bundle
//
// Purpose: groups the control inputs and PC outputs of program_counter_unit.
// Modports:
//   master : core control side; drives stall/pc_sel/imm/rs1/halt_req/resume, observes the PC outputs
//   slave  : program_counter_unit side
// Signals:
//   stall        hold PC this cycle
//   pc_sel       00 seq, 01 branch (pc+imm), 10 jalr ((rs1+imm)&~1), 11 trap
//   imm          sign-extended immediate
//   rs1          jalr base register value
//   halt_req     enter HALT
//   resume       leave HALT
//   pc_out       current fetch PC (registered)
//   pc_plus_inc  pc_out + INC, link value (combinational)
//   pc_valid     pc_out is fetchable (registered)
//   misalign_exc one-cycle pulse on a misaligned redirect
interface program_counter_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_inc;
  logic            pc_valid;
  logic            misalign_exc;

  modport master (
    output stall, pc_sel, imm, rs1, halt_req, resume,
    input  pc_out, pc_plus_inc, pc_valid, misalign_exc
  );

  modport slave (
    input  stall, pc_sel, imm, rs1, halt_req, resume,
    output pc_out, pc_plus_inc, pc_valid, misalign_exc
  );
endinterface

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - PC register and next-PC generator for the fetch stage
//
// Purpose: holds the fetch PC, selects sequential/branch/jalr/trap targets, holds on
//   stall with a one-entry pending redirect buffer, provides BOOT/RUN/HALT control and
//   alignment handling of every loaded target.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; wins over every other input
//   bus    program_counter_unit_if.slave (see interface file for signal list)
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   defined   : a misaligned target loads TRAP_VECTOR and pulses misalign_exc with the load
//   undefined : misaligned low bits are cleared before loading; misalign_exc stays 0
module program_counter_unit #(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input logic                  clk,
  input logic                  reset,
  program_counter_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Low address bits that must be zero for a fetchable target.
  localparam logic [XLEN-1:0] ALIGN_MASK = (INC == 4) ? XLEN'(3) : XLEN'(1);
  localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            exc_q, exc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] run_target;
  logic [XLEN-1:0] load_target;
  logic            load_exc;
  logic            redirect;

  assign seq_target = pc_q + INC_X;
  assign jalr_sum   = bus.rs1 + bus.imm;
  assign redirect   = (bus.pc_sel != 2'b00);

  always_comb begin
    sel_target = seq_target;
    case (bus.pc_sel)
      2'b01:   sel_target = pc_q + bus.imm;
      2'b10:   sel_target = {jalr_sum[XLEN-1:1], 1'b0};
      2'b11:   sel_target = TRAP_VECTOR;
      default: sel_target = seq_target;
    endcase
  end

  // An explicit redirect this cycle beats a buffered one; a buffered one beats seq.
  assign run_target = redirect     ? sel_target :
                      pend_valid_q ? pend_target_q : seq_target;

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned  = |(run_target & ALIGN_MASK);
  assign load_target = misaligned ? TRAP_VECTOR : run_target;
  assign load_exc    = misaligned;
`else
  assign load_target = run_target & ~ALIGN_MASK;
  assign load_exc    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    exc_d         = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    case (state_q)
      S_BOOT: begin
        // PC stays at the reset vector so it is the first valid fetch address.
        state_d      = S_RUN;
        valid_d      = 1'b1;
        pend_valid_d = 1'b0;
      end
      S_RUN: begin
        valid_d = 1'b1;
        if (bus.stall) begin
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = sel_target;
          end
        end else begin
          pc_d         = load_target;
          exc_d        = load_exc;
          pend_valid_d = 1'b0;
          // The selected target is still loaded on the halting edge.
          if (bus.halt_req) begin
            state_d = S_HALT;
            valid_d = 1'b0;
          end
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
        if (bus.resume) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      valid_q       <= 1'b0;
      exc_q         <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      exc_q         <= exc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_plus_inc  = seq_target;
  assign bus.pc_valid     = valid_q;
  assign bus.misalign_exc = exc_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// tb/tb_program_counter_unit.sv - scoreboard bench for program_counter_unit
module tb_program_counter_unit;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        exc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];
  string tag_q[$];
  logic [31:0] exp_pc_now;
  bit   have_exp;

  program_counter_unit_if #(.XLEN(32)) pc_if ();

  program_counter_unit #(
    .XLEN(32),
    .INC(4),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR(32'h0000_0100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(pc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what the PC must look like after the edge,
  // then pop and compare once the DUT has updated.
  task automatic step(input string tag, input logic rst, input logic st,
                      input logic [1:0] sel, input logic [31:0] imm_v, input logic [31:0] rs1_v,
                      input logic halt, input logic res,
                      input logic [31:0] e_pc, input logic e_valid, input logic e_exc);
    exp_t  e;
    string t;
    reset           = rst;
    pc_if.stall     = st;
    pc_if.pc_sel    = sel;
    pc_if.imm       = imm_v;
    pc_if.rs1       = rs1_v;
    pc_if.halt_req  = halt;
    pc_if.resume    = res;
    if (have_exp) check_eq({tag, ".link"}, pc_if.pc_plus_inc, exp_pc_now + 32'd4);
    e.pc    = e_pc;
    e.valid = e_valid;
    e.exc   = e_exc;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, ".pc"}, pc_if.pc_out, e.pc);
      check_eq({t, ".valid"}, {31'd0, pc_if.pc_valid}, {31'd0, e.valid});
      check_eq({t, ".exc"}, {31'd0, pc_if.misalign_exc}, {31'd0, e.exc});
      exp_pc_now = e.pc;
      have_exp   = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] mis_pc;
    logic [31:0] after_pc;
    logic [31:0] pend_pc;
    n_cmp    = 0;
    n_err    = 0;
    have_exp = 1'b0;
    exp_pc_now = 32'd0;
    reset = 1'b1;
    pc_if.stall = 1'b0; pc_if.pc_sel = 2'b00; pc_if.imm = '0; pc_if.rs1 = '0;
    pc_if.halt_req = 1'b0; pc_if.resume = 1'b0;
    @(negedge clk);

    mis_pc   = TRAP_EN ? 32'h0000_0100 : 32'h0000_0014;
    after_pc = TRAP_EN ? 32'h0000_0104 : 32'h0000_0018;
    pend_pc  = TRAP_EN ? 32'h0000_0100 : 32'h0000_0200;

    // reset, boot, sequential run
    step("rst0",   1, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
    step("rst1",   1, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
    step("boot",   0, 0, 2'b01, 32'h40, 32'h0, 0, 0, 32'h0, 1, 0);
    step("seq1",   0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h4, 1, 0);
    step("stall_halt", 0, 1, 2'b00, 32'h0, 32'h0, 1, 0, 32'h4, 1, 0);
    step("seq2",   0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h8, 1, 0);
    step("seq3",   0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'hC, 1, 0);
    // wrap-around
    step("br_top", 0, 0, 2'b01, 32'hFFFF_FFF0, 32'h0, 0, 0, 32'hFFFF_FFFC, 1, 0);
    step("wrap",   0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0);
    // branch / jalr / trap targets
    step("trap",   0, 0, 2'b11, 32'h0, 32'h0, 0, 0, 32'h100, 1, 0);
    step("br_neg", 0, 0, 2'b01, 32'hFFFF_FFF0, 32'h0, 0, 0, 32'hF0, 1, 0);
    step("jalr",   0, 0, 2'b10, 32'h0, 32'h2001, 0, 0, 32'h2000, 1, 0);
    step("jalr40", 0, 0, 2'b10, 32'h0, 32'h40, 0, 0, 32'h40, 1, 0);
    // redirect captured during a stall
    step("stall1", 0, 1, 2'b01, 32'h20, 32'h0, 0, 0, 32'h40, 1, 0);
    step("stall2", 0, 1, 2'b00, 32'h0, 32'h0, 0, 0, 32'h40, 1, 0);
    step("stall3", 0, 1, 2'b00, 32'h0, 32'h0, 0, 0, 32'h40, 1, 0);
    step("unstall", 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h60, 1, 0);
    // newest pending wins; explicit redirect beats pending
    step("new_a",  0, 1, 2'b01, 32'h10, 32'h0, 0, 0, 32'h60, 1, 0);
    step("new_b",  0, 1, 2'b10, 32'h0, 32'h300, 0, 0, 32'h60, 1, 0);
    step("new_ap", 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h300, 1, 0);
    step("ovr_a",  0, 1, 2'b01, 32'h8, 32'h0, 0, 0, 32'h300, 1, 0);
    step("ovr_ap", 0, 0, 2'b11, 32'h0, 32'h0, 0, 0, 32'h100, 1, 0);
    // misalignment
    step("jalr10", 0, 0, 2'b10, 32'h0, 32'h10, 0, 0, 32'h10, 1, 0);
    step("mis_br", 0, 0, 2'b01, 32'h6, 32'h0, 0, 0, mis_pc, 1, TRAP_EN);
    step("mis_nx", 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, after_pc, 1, 0);
    step("mis_pst", 0, 1, 2'b10, 32'h0, 32'h203, 0, 0, after_pc, 1, 0);
    step("mis_pap", 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, pend_pc, 1, TRAP_EN);
    // halt / resume
    step("jalr80", 0, 0, 2'b10, 32'h0, 32'h80, 0, 0, 32'h80, 1, 0);
    step("halt",   0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 32'h84, 0, 0);
    for (int i = 0; i < 5; i++)
      step("halt_hold", 0, 0, 2'b01, 32'h40, 32'h0, 0, 0, 32'h84, 0, 0);
    step("resume", 0, 0, 2'b00, 32'h0, 32'h0, 0, 1, 32'h84, 1, 0);
    step("res_seq", 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h88, 1, 0);
    step("halt_br", 0, 0, 2'b01, 32'h10, 32'h0, 1, 0, 32'h98, 0, 0);
    step("rst_halt", 1, 0, 2'b00, 32'h0, 32'h0, 0, 1, 32'h0, 0, 0);
    step("boot2",  0, 0, 2'b11, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0);
    step("seq_b2", 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h4, 1, 0);

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
